fifo_rd_stream: RTL and testbench

Read-side drain engine for the synchronous `fifo` block. It pops words from the FIFO read port and presents them on a valid/ready output stream. It absorbs the FIFO's one-cycle read latency in a 3-entry output buffer, so back-pressure is supported with no combinational path from `m_ready` to `fifo_rd_en`. It sits between the FIFO read port and any downstream consumer, and also provides a flush (discard-all) mode and a delivered-word counter.

---
 rtl/fifo_rd_stream_if.sv | 11 +
 rtl/fifo_rd_stream.sv | 112 +++++++++++
 tb/tb_fifo_rd_stream.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carrying words drained from the FIFO read port.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: pops FIFO words into a 3-entry buffer that feeds a
// valid/ready stream, with flush (discard-all) mode and a delivered-word counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_rd_stream_if.master      m_if,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy,
  output logic                  flush_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  flush_done_q, flush_done_d;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign m_if.m_valid = (occ_q != 2'd0);
  assign m_if.m_data  = (occ_q != 2'd0) ? buf_q[head_q] : '0;
  assign pop          = m_if.m_valid && m_if.m_ready;
  assign capture      = inflight_q && (state_q == RUN);
  assign rd_count     = cnt_q;
  assign flush_done   = flush_done_q;
  assign busy         = (state_q != IDLE) || (occ_q != 2'd0) || inflight_q;

  // Read strobe depends only on registered state and the FIFO flag, never on m_ready.
  always_comb begin
    fifo_rd_en = 1'b0;
    unique case (state_q)
      RUN:     fifo_rd_en = en && !fifo_empty && ((3'(occ_q) + 3'(inflight_q)) < 3'd3);
      FLUSH:   fifo_rd_en = !fifo_empty;
      default: fifo_rd_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;

    if (pop) begin
      head_d = ptr_inc(head_q);
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end
    if (capture) tail_d = ptr_inc(tail_q);
    if (capture && !pop)      occ_d = occ_q + 2'd1;
    else if (!capture && pop) occ_d = occ_q - 2'd1;

    if (flush) begin
      state_d = FLUSH;
      occ_d   = 2'd0;
      head_d  = 2'd0;
      tail_d  = 2'd0;
    end else begin
      unique case (state_q)
        IDLE:    if (en) state_d = RUN;
        RUN:     if (!en && (occ_q == 2'd0) && !inflight_q) state_d = IDLE;
        FLUSH:   if (fifo_empty && !inflight_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    flush_done_d = (state_q == FLUSH) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q      <= IDLE;
      occ_q        <= 2'd0;
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      inflight_q   <= 1'b0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      inflight_q   <= fifo_rd_en;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Buffer storage carries data only; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (capture) buf_q[tail_q] <= fifo_data_out;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO and a queue-based cycle reference model.
module tb_fifo_rd_stream;
  localparam int DW      = 8;
  localparam int CW      = 16;
  localparam int IDLE_M  = 0;
  localparam int RUN_M   = 1;
  localparam int FLUSH_M = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN, en, flush, fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_en, busy, flush_done;
  logic [CW-1:0] rd_count;
  logic          rd_en4, busy4, flush_done4;
  logic [3:0]    rd_count4;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();
  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s4_if ();
  assign s4_if.m_ready = s_if.m_ready;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstN(rstN), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_if(s_if),
    .rd_count(rd_count), .busy(busy), .flush_done(flush_done));

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rstN(rstN), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(rd_en4), .m_if(s4_if),
    .rd_count(rd_count4), .busy(busy4), .flush_done(flush_done4));

  // FIFO model and reference model state
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] mbuf [$];
  logic          minfl;
  int            mmode;
  int            mcount;
  logic          mfd;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  cmp_on   = 1'b0;
  int  cyc      = 0;
  int  rd_pulses, fd_pulses, hs_cnt, hs_first, hs_last;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    if (fifo_q.size() < 32) fifo_q.push_back(w);
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic step();
    logic          exp_v, exp_rd, rd;
    logic [DW-1:0] exp_d;
    int            nm;
    #1;
    exp_v  = (mbuf.size() != 0);
    exp_d  = exp_v ? mbuf[0] : '0;
    exp_rd = 1'b0;
    if (mmode == RUN_M)   exp_rd = en && !fifo_empty && ((mbuf.size() + int'(minfl)) < 3);
    if (mmode == FLUSH_M) exp_rd = !fifo_empty;
    if (cmp_on) begin
      check("m_valid",    32'(s_if.m_valid), 32'(exp_v));
      check("m_data",     32'(s_if.m_data),  32'(exp_d));
      check("fifo_rd_en", 32'(fifo_rd_en),   32'(exp_rd));
      check("busy",       32'(busy), 32'((mmode != IDLE_M) || exp_v || minfl));
      check("flush_done", 32'(flush_done),   32'(mfd));
      check("rd_count",   32'(rd_count),     32'(mcount % 65536));
      check("rd_count4",  32'(rd_count4),    32'(mcount % 16));
      check("m_valid4",   32'(s4_if.m_valid), 32'(exp_v));
      check("m_data4",    32'(s4_if.m_data),  32'(exp_d));
      check("rd_en4",     32'(rd_en4),        32'(exp_rd));
      check("busy4",      32'(busy4),         32'(busy));
      check("flush_done4", 32'(flush_done4),  32'(mfd));
      check("rd_when_empty", 32'(fifo_rd_en && fifo_empty), 32'(0));
    end
    rd = fifo_rd_en;
    rd_pulses += int'(rd);
    fd_pulses += int'(flush_done);

    if (!rstN) begin
      mbuf.delete();
      minfl  = 1'b0;
      mmode  = IDLE_M;
      mcount = 0;
      mfd    = 1'b0;
    end else begin
      nm = mmode;
      if (exp_v && s_if.m_ready) begin
        void'(mbuf.pop_front());
        mcount++;
        if (hs_cnt == 0) hs_first = cyc;
        hs_last = cyc;
        hs_cnt++;
      end
      if (minfl && mmode == RUN_M) mbuf.push_back(fifo_data_out);
      if (flush) begin
        mbuf.delete();
        nm = FLUSH_M;
      end else if (mmode == IDLE_M && en) nm = RUN_M;
      else if (mmode == RUN_M && !en && !exp_v && !minfl) nm = IDLE_M;
      else if (mmode == FLUSH_M && fifo_empty && !minfl) nm = IDLE_M;
      mfd   = (mmode == FLUSH_M) && (nm == IDLE_M);
      mmode = nm;
      minfl = exp_rd;
    end

    if (rd && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    fifo_data_out = fifo_dout;
    fifo_empty    = (fifo_q.size() == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    en = 1'b0;
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 60 && busy; i++) step();
    check("drain_idle", 32'(busy), 32'(0));
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 60 && busy; i++) step();
    check("flush_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    rstN = 1'b0; en = 1'b0; flush = 1'b0; fifo_empty = 1'b1;
    fifo_data_out = '0; fifo_dout = '0; s_if.m_ready = 1'b0;
    mmode = IDLE_M; minfl = 1'b0; mcount = 0; mfd = 1'b0;
    rd_pulses = 0; fd_pulses = 0; hs_cnt = 0; hs_first = 0; hs_last = 0;
    @(negedge clk);
    steps(2);
    cmp_on = 1'b1;
    rstN = 1'b1;
    step();

    // Three words, free-flowing consumer
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1; s_if.m_ready = 1'b1;
    steps(8);
    drain();
    check("t1_count", 32'(rd_count), 32'(3));

    // Back-pressure: only three reads outstanding
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    en = 1'b1; s_if.m_ready = 1'b0; rd_pulses = 0;
    steps(10);
    check("bp_reads", 32'(rd_pulses), 32'(3));
    check("bp_head", 32'(s_if.m_data), 32'(8'h40));
    s_if.m_ready = 1'b1;
    steps(14);
    drain();
    check("bp_count", 32'(rd_count), 32'(11));

    // Full FIFO at one word per cycle
    for (int i = 0; i < 32; i++) push(8'($urandom));
    hs_cnt = 0; en = 1'b1; s_if.m_ready = 1'b1;
    steps(40);
    drain();
    check("full_pops", 32'(hs_cnt), 32'(32));
    check("full_span", 32'(hs_last - hs_first + 1), 32'(32));
    check("full_empty", 32'(fifo_q.size()), 32'(0));

    // Flush after two words are buffered
    rstN = 1'b0; step(); rstN = 1'b1;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    en = 1'b1; s_if.m_ready = 1'b0;
    for (int i = 0; i < 20 && mbuf.size() < 2; i++) step();
    check("fl_buffered", 32'(s_if.m_valid), 32'(1));
    fd_pulses = 0; en = 1'b0;
    flush_fifo();
    steps(3);
    check("fl_done_once", 32'(fd_pulses), 32'(1));
    check("fl_count", 32'(rd_count), 32'(0));
    check("fl_empty", 32'(fifo_q.size()), 32'(0));

    // Drop en with three buffered words
    for (int i = 0; i < 5; i++) push(8'($urandom));
    en = 1'b1; s_if.m_ready = 1'b0;
    for (int i = 0; i < 20 && mbuf.size() < 3; i++) step();
    en = 1'b0; rd_pulses = 0;
    steps(3);
    check("stop_reads", 32'(rd_pulses), 32'(0));
    drain();
    check("stop_count", 32'(rd_count), 32'(3));
    check("stop_left", 32'(fifo_q.size()), 32'(2));
    flush_fifo();

    // Reset while a read is in flight
    for (int i = 0; i < 6; i++) push(8'($urandom));
    en = 1'b1; s_if.m_ready = 1'b1;
    for (int i = 0; i < 20 && !minfl; i++) step();
    rstN = 1'b0; step(); rstN = 1'b1;
    check("rst_valid", 32'(s_if.m_valid), 32'(0));
    check("rst_count", 32'(rd_count), 32'(0));
    for (int i = 0; i < 40 && fifo_q.size() != 0; i++) step();
    steps(3);
    drain();

    // 17 deliveries wrap the narrow counter to 1
    rstN = 1'b0; step(); rstN = 1'b1;
    for (int i = 0; i < 17; i++) push(8'($urandom));
    en = 1'b1; s_if.m_ready = 1'b1;
    steps(22);
    drain();
    check("wrap4", 32'(rd_count4), 32'(1));
    check("wrap16", 32'(rd_count), 32'(17));

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      en           = ($urandom_range(99) < 80);
      flush        = ($urandom_range(99) < 3);
      s_if.m_ready = ($urandom_range(99) < 60);
      rstN         = ($urandom_range(199) != 0);
      if ($urandom_range(99) < 45) push(8'($urandom));
      step();
    end
    rstN = 1'b1; en = 1'b0;
    flush_fifo();
    check("end_empty", 32'(fifo_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
